// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: per-channel control and divided-clock outputs of clk_div_multi
interface clk_div_multi_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 8
);
  logic [N_CH-1:0]       clk_en;
  logic [N_CH*DIV_W-1:0] div_ratio;
  logic                  sync;
  logic [N_CH-1:0]       div_clk;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       active;
  modport master (output clk_en, div_ratio, sync, input div_clk, tick, active);
  modport slave  (input clk_en, div_ratio, sync, output div_clk, tick, active);
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel integer clock divider with period-boundary ratio loads and global sync
module clk_div_multi #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 8
) (
  input logic            ref_clk,
  input logic            rst,
  clk_div_multi_if.slave bus
);
  // bit 0 of the state is the RUN flag, bit 1 the bypass select, so both come straight from flops
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, BYPASS = 2'b10} st_t;
  st_t              st  [N_CH];
  logic [DIV_W-1:0] cnt [N_CH];
  logic [DIV_W-1:0] act [N_CH];
  logic [DIV_W-1:0] r   [N_CH];
  logic [N_CH-1:0]  q, tick, ok, last, run, byp;
  always_comb begin
    ok   = '0;
    last = '0;
    run  = '0;
    byp  = '0;
    for (int c = 0; c < N_CH; c++) begin
      r[c]    = bus.div_ratio[c*DIV_W +: DIV_W];
      ok[c]   = r[c] > DIV_W'(1);
      last[c] = bus.sync | (cnt[c] == act[c] - DIV_W'(1));
      run[c]  = st[c][0];
      byp[c]  = st[c][1];
    end
  end
  always_ff @(posedge ref_clk or posedge rst)
    if (rst) begin
      q    <= '0;
      tick <= '0;
      for (int c = 0; c < N_CH; c++) begin
        st[c]  <= IDLE;
        cnt[c] <= '0;
        act[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++)
        if ((st[c] != RUN || last[c]) && bus.clk_en[c] && ok[c]) begin
          st[c]   <= RUN;
          act[c]  <= r[c];
          cnt[c]  <= '0;
          q[c]    <= 1'b1;
          tick[c] <= 1'b1;
        end else if (st[c] == RUN && !last[c]) begin
          cnt[c]  <= cnt[c] + DIV_W'(1);
          q[c]    <= (cnt[c] + DIV_W'(1)) < (act[c] >> 1);
          tick[c] <= 1'b0;
        end else begin
          st[c]   <= bus.clk_en[c] ? BYPASS : IDLE;
          q[c]    <= 1'b0;
          tick[c] <= 1'b0;
        end
    end
  assign bus.div_clk = (byp & {N_CH{ref_clk}}) | (q & ~byp);
  assign bus.tick    = tick;
  assign bus.active  = run;
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed vector table plus hand-written corner sequences for clk_div_multi
module tb_clk_div_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  clk_div_multi_if #(.N_CH(4), .DIV_W(8)) bus();
  clk_div_multi #(.N_CH(4), .DIV_W(8)) dut (.ref_clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  en;
    logic [31:0] ratio;
    logic [3:0]  dclk;
    logic [3:0]  tick;
    logic [3:0]  active;
  } vec_t;
  vec_t tbl [10];
  logic [3:0] ce [10] = '{4'b0111, 4'b0011, 4'b0000, 4'b0100, 4'b0001,
                          4'b0011, 4'b0110, 4'b0000, 4'b0001, 4'b0101};
  logic [3:0] te [10] = '{4'b0111, 4'b0000, 4'b0000, 4'b0100, 4'b0001,
                          4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b0100};
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.clk_en = '0;
    bus.div_ratio = '0;
    bus.sync = 1'b0;
    #2;
    rst = 1'b0;
  endtask
  // one character per edge for channel 0: div_clk, tick, active
  task automatic seq(input string name, input string qs, input string ts, input string as);
    for (int i = 0; i < qs.len(); i++) begin
      step();
      chk({name, "_clk"}, bus.div_clk[0], qs[i] == 8'h31);
      chk({name, "_tick"}, bus.tick[0], ts[i] == 8'h31);
      chk({name, "_active"}, bus.active[0], as[i] == 8'h31);
    end
  endtask
  initial begin
    for (int i = 0; i < 10; i++)
      tbl[i] = '{en: 4'b0111, ratio: 32'h00_03_05_04, dclk: ce[i], tick: te[i], active: 4'b0111};
    bus.clk_en = '0;
    bus.div_ratio = '0;
    bus.sync = 1'b0;
    step();
    chk("reset_clk", bus.div_clk, 4'b0000);
    chk("reset_tick", bus.tick, 4'b0000);
    chk("reset_active", bus.active, 4'b0000);
    rst = 1'b0;
    // ch0 R=4, ch1 R=5, ch2 R=3 from reset release
    for (int i = 0; i < 10; i++) begin
      bus.clk_en = tbl[i].en;
      bus.div_ratio = tbl[i].ratio;
      step();
      chk($sformatf("tbl%0d_clk", i), bus.div_clk, tbl[i].dclk);
      chk($sformatf("tbl%0d_tick", i), bus.tick, tbl[i].tick);
      chk($sformatf("tbl%0d_active", i), bus.active, tbl[i].active);
    end
    // ratio 4 -> 6 while cnt=1: current period completes first
    do_reset();
    bus.clk_en = 4'b0001;
    bus.div_ratio = 32'd4;
    seq("r4", "11", "10", "11");
    bus.div_ratio = 32'd6;
    seq("r4to6", "001110001", "001000001", "111111111");
    // bypass with R=0, then R=1, then R=2 starts RUN
    do_reset();
    bus.clk_en = 4'b0001;
    bus.div_ratio = 32'd0;
    step();
    chk("byp_hi", bus.div_clk[0], 1'b1);
    chk("byp_active", bus.active[0], 1'b0);
    chk("byp_tick", bus.tick[0], 1'b0);
    @(negedge clk);
    #1;
    chk("byp_lo", bus.div_clk[0], 1'b0);
    bus.div_ratio = 32'd1;
    step();
    chk("byp1_hi", bus.div_clk[0], 1'b1);
    chk("byp1_active", bus.active[0], 1'b0);
    bus.div_ratio = 32'd2;
    seq("r2", "101", "101", "111");
    // enable dropped at cnt=2 of an 8-cycle period
    do_reset();
    bus.clk_en = 4'b0001;
    bus.div_ratio = 32'd8;
    seq("r8", "111", "100", "111");
    bus.clk_en = 4'b0000;
    seq("endrop", "100000", "000000", "111110");
    // sync: ch0 R=4, ch1 R=6, ch2 bypass
    do_reset();
    bus.clk_en = 4'b0111;
    bus.div_ratio = 32'h00_01_06_04;
    seq("pre", "110", "100", "111");
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("sync_clk", bus.div_clk[1:0], 2'b11);
    chk("sync_tick", bus.tick[1:0], 2'b11);
    chk("sync_active", bus.active, 4'b0011);
    chk("sync_byp", bus.div_clk[2], 1'b1);
    step();
    step();
    step();
    chk("pre_end_clk", bus.div_clk[1:0], 2'b00);
    bus.clk_en = 4'b0101;
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("sync_end_tick", bus.tick[1:0], 2'b01);
    chk("sync_end_clk", bus.div_clk[1:0], 2'b01);
    chk("sync_end_active", bus.active, 4'b0001);
    step();
    chk("no_double_tick", bus.tick[0], 1'b0);
    chk("post_sync_clk", bus.div_clk[0], 1'b1);
    // reset mid-run while ref_clk is high and ch2 is in bypass
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_clk", bus.div_clk, 4'b0000);
    chk("midrst_tick", bus.tick, 4'b0000);
    chk("midrst_active", bus.active, 4'b0000);
    bus.clk_en = 4'b0001;
    bus.div_ratio = 32'd4;
    bus.sync = 1'b0;
    rst = 1'b0;
    seq("restart", "1100", "1000", "1111");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
